dot_matrix_scan: RTL

Row-scan driver for the 8×8 LED dot matrix, directly downstream of the picture-lookup stage that outputs the 64-bit bitmap `MUX_COL`. It latches one full bitmap per frame, so the display never shows a torn frame. It then time-multiplexes the eight rows onto the matrix row/column pins. Each row slot has a programmable blanking interval to suppress ghosting, and the block provides a frame-start strobe for upstream animation sequencing.

---
 rtl/dot_matrix_scan.sv | 98 +++++++++
 1 files changed

// File: rtl/dot_matrix_scan.sv
// Row-scan driver for an 8x8 LED matrix: latches one bitmap per frame and
// time-multiplexes its rows with a blanking interval at the start of each slot.
module dot_matrix_scan #(
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int ROW_ACTIVE_LOW = 1,
    parameter int COL_ACTIVE_LOW = 0
) (
    input  logic        Sys_Clk,
    input  logic        Sys_Rst,
    input  logic [63:0] MUX_COL,
    input  logic        Disp_En,
    output logic [7:0]  Row_Out,
    output logic [7:0]  Col_Out,
    output logic [2:0]  Row_Idx,
    output logic        Frame_Start
);

    localparam int              CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK_CYCLES);
    localparam logic            ROW_INACT = (ROW_ACTIVE_LOW != 0);
    localparam logic            COL_INACT = (COL_ACTIVE_LOW != 0);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [2:0]       row, nxt_row;
    logic [63:0]      fb, nxt_fb;
    logic             nxt_fs;
    logic             drive;

    function automatic logic [7:0] row_level(input logic drv, input logic [2:0] r);
        logic [7:0] onehot;
        onehot = 8'h01 << r;
        return drv ? (onehot ^ {8{ROW_INACT}}) : {8{ROW_INACT}};
    endfunction

    function automatic logic [7:0] col_level(input logic drv, input logic [7:0] bits);
        return drv ? (bits ^ {8{COL_INACT}}) : {8{COL_INACT}};
    endfunction

    // Next-state values; the outputs are registered from these so they always
    // describe the state the counters are entering on the same edge.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_row   = row;
        nxt_fb    = fb;
        nxt_fs    = 1'b0;
        if (!Disp_En) begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
            nxt_row   = '0;
        end else if (state == IDLE) begin
            nxt_state = SCAN;
            nxt_cnt   = '0;
            nxt_row   = '0;
            nxt_fb    = MUX_COL;
            nxt_fs    = 1'b1;
        end else if (cnt == CNT_MAX) begin
            nxt_cnt = '0;
            nxt_row = row + 3'd1;
            if (row == 3'd7) begin
                nxt_fb = MUX_COL;
                nxt_fs = 1'b1;
            end
        end else begin
            nxt_cnt = cnt + CNT_W'(1);
        end
    end

    assign drive = (nxt_state == SCAN) && (nxt_cnt >= BLANK_C);

    always_ff @(posedge Sys_Clk or negedge Sys_Rst) begin
        if (!Sys_Rst) begin
            state       <= IDLE;
            cnt         <= '0;
            row         <= '0;
            fb          <= '0;
            Row_Out     <= {8{ROW_INACT}};
            Col_Out     <= {8{COL_INACT}};
            Row_Idx     <= '0;
            Frame_Start <= 1'b0;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            row         <= nxt_row;
            fb          <= nxt_fb;
            Row_Out     <= row_level(drive, nxt_row);
            Col_Out     <= col_level(drive, nxt_fb[{nxt_row, 3'b000} +: 8]);
            Row_Idx     <= nxt_row;
            Frame_Start <= nxt_fs;
        end
    end

endmodule
